// File: rtl/cfu_accel_pkg.sv
// Shared types and sizes for the CFU accelerator input path.
package cfu_accel_pkg;
  localparam int DEPTH_DEF = 128;
  localparam int CNT_W     = 9;
  localparam int DATA_W    = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_SETTLE,
    S_PRESENT,
    S_DONE
  } drain_state_e;
endpackage

// File: rtl/cfu_input_drain_ctrl.sv
// Drains the CFU input buffer in fixed-length bursts onto a valid/ready stream; at most one word per two cycles.
// Optional stall performance counter enabled by CFU_DRAIN_PERF_EN.
module cfu_input_drain_ctrl
  import cfu_accel_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int NB_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  burst_len,
  input  logic [NB_W-1:0]   num_bursts,
  output logic              buf_read_en,
  output logic              buf_clear,
  input  logic [DATA_W-1:0] buf_read_data,
  input  logic [CNT_W-1:0]  buf_count,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       stall_cycles
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam int               NBP     = NB_W + 1;

  drain_state_e     state_q, state_d;
  logic [CNT_W-1:0] blen_q, blen_d;
  logic [NB_W-1:0]  nbur_q, nbur_d;
  logic [CNT_W-1:0] wcnt_q, wcnt_d;
  logic [NB_W-1:0]  bcnt_q, bcnt_d;
  logic             err_q, err_d;
  logic             clr_q;

  logic illegal_cfg;
  logic start_ok;
  logic last_word;
  logic more_bursts;

  assign illegal_cfg = (burst_len == '0) || (burst_len > DEPTH_C) || (num_bursts == '0);
  assign start_ok    = (state_q == S_IDLE) && start && !abort && !illegal_cfg;
  assign last_word   = (wcnt_q == blen_q - CNT_W'(1));
  assign more_bursts = ({1'b0, bcnt_q} + NBP'(1)) < {1'b0, nbur_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      blen_q  <= '0;
      nbur_q  <= '0;
      wcnt_q  <= '0;
      bcnt_q  <= '0;
      err_q   <= 1'b0;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      blen_q  <= blen_d;
      nbur_q  <= nbur_d;
      wcnt_q  <= wcnt_d;
      bcnt_q  <= bcnt_d;
      err_q   <= err_d;
      clr_q   <= abort;
    end
  end

  always_comb begin
    state_d = state_q;
    blen_d  = blen_q;
    nbur_d  = nbur_q;
    wcnt_d  = wcnt_q;
    bcnt_d  = bcnt_q;
    err_d   = 1'b0;
    // Abort overrides any start or handshake in the same cycle.
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            if (illegal_cfg) begin
              err_d = 1'b1;
            end else begin
              blen_d  = burst_len;
              nbur_d  = num_bursts;
              wcnt_d  = '0;
              bcnt_d  = '0;
              state_d = S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (buf_count >= blen_q) state_d = S_SETTLE;
        end
        // Buffer read data lags a pointer move or first write by one cycle.
        S_SETTLE: state_d = S_PRESENT;
        S_PRESENT: begin
          if (out_ready) begin
            wcnt_d = wcnt_q + CNT_W'(1);
            if (!last_word) begin
              state_d = S_SETTLE;
            end else if (more_bursts) begin
              wcnt_d  = '0;
              bcnt_d  = bcnt_q + NB_W'(1);
              state_d = S_WAIT;
            end else begin
              state_d = S_DONE;
            end
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign out_valid   = (state_q == S_PRESENT);
  assign out_data    = out_valid ? buf_read_data : '0;
  assign out_last    = out_valid && last_word;
  assign buf_read_en = out_valid && out_ready && !abort;
  assign buf_clear   = clr_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign err         = err_q;

`ifdef CFU_DRAIN_PERF_EN
  logic [31:0] stall_q;
  logic        stall_inc;

  assign stall_inc = (state_q == S_WAIT) || ((state_q == S_PRESENT) && !out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (start_ok) begin
      stall_q <= '0;
    end else if (stall_inc && (stall_q != '1)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_cfu_input_drain_ctrl.sv
// Directed bench for cfu_input_drain_ctrl with a registered-prefetch input buffer model.
module tb_cfu_input_drain_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, start, abort;
  logic [8:0]  burst_len;
  logic [15:0] num_bursts;
  logic        buf_read_en, buf_clear;
  logic [31:0] buf_read_data = '0;
  logic [8:0]  buf_count = '0;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_last, out_ready, busy, done, err;
  logic [31:0] stall_cycles;

  cfu_input_drain_ctrl #(.DEPTH(128), .NB_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .burst_len(burst_len), .num_bursts(num_bursts),
    .buf_read_en(buf_read_en), .buf_clear(buf_clear),
    .buf_read_data(buf_read_data), .buf_count(buf_count),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready), .busy(busy), .done(done), .err(err),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [31:0] q[$];
  logic        push_req = 1'b0;
  logic [31:0] push_dat = '0;
  logic        pop_n = 1'b0;
  logic        clr_n = 1'b0;

  logic [31:0] cap_d[$];
  logic        cap_l[$];
  int          hs_cnt, pop_cnt, done_cnt, done_cyc, last_hs_cyc, first_v_cyc;
  logic [31:0] first_v_dat;
  logic [8:0]  first_v_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Buffer model: read data shows the head as it stood before this edge.
  initial forever begin
    @(posedge clk);
    cyc++;
    buf_read_data <= (q.size() > 0) ? q[0] : 32'h0;
    if (clr_n) q.delete();
    else begin
      if (pop_n && q.size() > 0) void'(q.pop_front());
      if (push_req) q.push_back(push_dat);
    end
    buf_count <= 9'(q.size());
    pop_n = 1'b0;
    clr_n = 1'b0;
  end

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (out_valid && out_ready) begin
        cap_d.push_back(out_data);
        cap_l.push_back(out_last);
        hs_cnt++;
        last_hs_cyc = cyc;
      end
      if (buf_read_en) pop_cnt++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (out_valid && first_v_cyc < 0) begin
        first_v_cyc = cyc;
        first_v_cnt = buf_count;
        first_v_dat = out_data;
      end
      pop_n = buf_read_en;
      clr_n = buf_clear;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] d);
    push_req = 1'b1;
    push_dat = d;
    step();
    push_req = 1'b0;
  endtask

  task automatic pulse_start(input logic [8:0] bl, input logic [15:0] nb);
    burst_len  = bl;
    num_bursts = nb;
    start      = 1'b1;
    step();
    start      = 1'b0;
  endtask

  task automatic clr_mon();
    cap_d.delete();
    cap_l.delete();
    hs_cnt = 0; pop_cnt = 0; done_cnt = 0; done_cyc = 0;
    last_hs_cyc = 0; first_v_cyc = -1; first_v_dat = '0; first_v_cnt = '0;
  endtask

  task automatic wait_done(input string tag, input int lim);
    int n = 0;
    while (done_cnt == 0 && n < lim) begin
      step();
      n++;
    end
    chk(tag, 32'(done_cnt), 32'd1);
  endtask

  task automatic wait_valid(input string tag, input int lim);
    int n = 0;
    while (!out_valid && n < lim) begin
      step();
      n++;
    end
    chk(tag, 32'(out_valid), 32'd1);
  endtask

  task automatic chk_words(input string tag, input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++)
      chk(tag, (i < cap_d.size()) ? cap_d[i] : 32'hdead_beef, base + 32'(i));
  endtask

  initial begin
    int t0;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    burst_len = '0; num_bursts = '0; out_ready = 1'b0;
    clr_mon();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_clear", 32'(buf_clear), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_stall", stall_cycles, 32'd0);
    chk("rst_re", 32'(buf_read_en), 32'd0);
    chk("rst_data", out_data, 32'd0);
    rst_n = 1'b1;
    step();

    // Two bursts of four from a preloaded buffer.
    clr_mon();
    for (int i = 0; i < 8; i++) push(32'h10 + 32'(i));
    out_ready = 1'b1;
    pulse_start(9'd4, 16'd2);
    t0 = cyc;
    chk("t1_busy", 32'(busy), 32'd1);
    wait_done("t1_done", 100);
    chk("t1_hs", 32'(hs_cnt), 32'd8);
    chk_words("t1_dat", 8, 32'h10);
    for (int i = 0; i < 8; i++)
      chk("t1_last", (i < cap_l.size()) ? 32'(cap_l[i]) : 32'hdead_beef, 32'((i == 3) || (i == 7)));
    chk("t1_pops", 32'(pop_cnt), 32'd8);
    chk("t1_done_lat", 32'(done_cyc - last_hs_cyc), 32'd1);
    chk("t1_first_lat", 32'(first_v_cyc - t0), 32'd2);
    chk("t1_idle", 32'(busy), 32'd0);
`ifdef CFU_DRAIN_PERF_EN
    chk("t1_stall", stall_cycles, 32'd2);
`else
    chk("t1_stall", stall_cycles, 32'd0);
`endif

    // Empty buffer filled slowly: presentation waits for a full burst.
    clr_mon();
    pulse_start(9'd3, 16'd1);
    for (int k = 0; k < 3; k++) begin
      repeat (4) step();
      push(32'hA0 + 32'(k));
    end
    wait_done("t2_done", 100);
    chk("t2_first_cnt", 32'(first_v_cnt), 32'd3);
    chk("t2_first_dat", first_v_dat, 32'hA0);
    chk("t2_hs", 32'(hs_cnt), 32'd3);
    chk_words("t2_dat", 3, 32'hA0);

    // Downstream stall mid-burst.
    clr_mon();
    for (int i = 0; i < 4; i++) push(32'h20 + 32'(i));
    out_ready = 1'b1;
    pulse_start(9'd4, 16'd1);
    begin
      int n = 0;
      while (hs_cnt < 2 && n < 50) begin
        step();
        n++;
      end
    end
    chk("t3_hs2", 32'(hs_cnt), 32'd2);
    out_ready = 1'b0;
    step();
    for (int j = 0; j < 6; j++) begin
      chk("t3_hold_valid", 32'(out_valid), 32'd1);
      chk("t3_hold_dat", out_data, 32'h22);
      chk("t3_hold_re", 32'(buf_read_en), 32'd0);
      step();
    end
    chk("t3_pops", 32'(pop_cnt), 32'd2);
`ifdef CFU_DRAIN_PERF_EN
    chk("t3_stall_ge6", 32'(stall_cycles >= 32'd6), 32'd1);
`else
    chk("t3_stall", stall_cycles, 32'd0);
`endif
    out_ready = 1'b1;
    wait_done("t3_done", 100);
    chk("t3_hs", 32'(hs_cnt), 32'd4);
    chk_words("t3_dat", 4, 32'h20);

    // Illegal configurations, then the largest legal burst length.
    clr_mon();
    pulse_start(9'd0, 16'd1);
    chk("t4_err_len0", 32'(err), 32'd1);
    chk("t4_busy_len0", 32'(busy), 32'd0);
    step();
    chk("t4_err_clr", 32'(err), 32'd0);
    pulse_start(9'd129, 16'd1);
    chk("t4_err_len129", 32'(err), 32'd1);
    chk("t4_busy_len129", 32'(busy), 32'd0);
    step();
    pulse_start(9'd4, 16'd0);
    chk("t4_err_nb0", 32'(err), 32'd1);
    chk("t4_busy_nb0", 32'(busy), 32'd0);
    step();
    pulse_start(9'd128, 16'd1);
    chk("t4_err_len128", 32'(err), 32'd0);
    chk("t4_busy_len128", 32'(busy), 32'd1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("t4_abort_idle", 32'(busy), 32'd0);
    step();

    // Abort while presenting, with a simultaneous ready.
    clr_mon();
    for (int i = 0; i < 4; i++) push(32'h30 + 32'(i));
    out_ready = 1'b0;
    pulse_start(9'd4, 16'd1);
    wait_valid("t5_valid", 20);
    abort = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("t5_re_abort", 32'(buf_read_en), 32'd0);
    step();
    abort = 1'b0;
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_clear", 32'(buf_clear), 32'd1);
    chk("t5_valid_off", 32'(out_valid), 32'd0);
    step();
    chk("t5_clear_off", 32'(buf_clear), 32'd0);
    chk("t5_no_done", 32'(done_cnt), 32'd0);
    chk("t5_pops", 32'(pop_cnt), 32'd0);
    chk("t5_flushed", 32'(buf_count), 32'd0);
    clr_mon();
    push(32'h40);
    push(32'h41);
    pulse_start(9'd2, 16'd1);
    wait_done("t5_re_done", 100);
    chk("t5_re_hs", 32'(hs_cnt), 32'd2);
    chk_words("t5_re_dat", 2, 32'h40);
    chk("t5_re_last", (cap_l.size() > 1) ? 32'(cap_l[1]) : 32'hdead_beef, 32'd1);

    // Asynchronous reset while presenting.
    clr_mon();
    push(32'h50);
    push(32'h51);
    out_ready = 1'b0;
    pulse_start(9'd2, 16'd1);
    wait_valid("t6_valid", 20);
    #2;
    out_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("t6_valid", 32'(out_valid), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_data", out_data, 32'd0);
    chk("t6_re", 32'(buf_read_en), 32'd0);
    chk("t6_last", 32'(out_last), 32'd0);
    repeat (2) step();
    rst_n = 1'b1;
    step();
    chk("t6_idle", 32'(busy), 32'd0);
    chk("t6_no_done", 32'(done_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cfu_input_drain_ctrl.md
# cfu_input_drain_ctrl

Read-side sequencer for the CFU input buffer FIFO. Drains the buffer in fixed-length bursts into the downstream MAC datapath through a valid/ready stream. Handles the buffer's registered-prefetch read latency so every presented word is valid. Sits between the input buffer and the accelerator compute pipeline; programmed per layer by the CFU op decoder.

## Interface
Parameters:
- DEPTH, 128, input buffer depth in words; upper bound on burst_len
- NB_W, 16, width of burst counter

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; latches burst_len/num_bursts, begins job
- abort  in  1  one-cycle pulse; cancels job and flushes buffer
- burst_len  in  9  words per burst, legal 1..DEPTH
- num_bursts  in  NB_W  bursts per job, legal ≥1
- buf_read_en  out  1  pop strobe to buffer (combinational)
- buf_clear  out  1  one-cycle flush pulse to buffer (registered)
- buf_read_data  in  32  buffer prefetch data
- buf_count  in  9  buffer occupancy
- out_valid  out  1  downstream word valid
- out_data  out  32  downstream word
- out_last  out  1  final word of current burst
- out_ready  in  1  downstream accept
- busy  out  1  job in progress
- done  out  1  one-cycle pulse at job completion
- err  out  1  one-cycle pulse on illegal start
- stall_cycles  out  32  performance counter (see Configuration)

## Operation
- States: IDLE, WAIT, SETTLE, PRESENT, DONE.
- IDLE: on start, if burst_len==0, burst_len>DEPTH or num_bursts==0 → pulse err, stay IDLE; else latch config, clear word_cnt/burst_cnt → WAIT.
- WAIT: buf_count ≥ latched burst_len → SETTLE. Whole burst must be resident before first word is presented.
- SETTLE: one cycle, no outputs; covers the buffer's one-cycle read_data refresh after a pointer move or empty→non-empty write → PRESENT.
- PRESENT: out_valid=1, out_data=buf_read_data. buf_read_en = (state==PRESENT) && out_ready. On handshake: word_cnt+1; if not last word of burst → SETTLE; if last word and burst_cnt+1 < num_bursts → word_cnt=0, burst_cnt+1, → WAIT; else → DONE.
- out_last = PRESENT && word_cnt == burst_len−1.
- DONE: done=1 for one cycle → IDLE.
- busy = (state != IDLE).
- start while busy: ignored, no err.
- abort in any non-IDLE state: → IDLE next edge, buf_clear=1 for one cycle, no done. Abort in IDLE: buf_clear still pulses. Abort wins over simultaneous start or handshake; buf_read_en is forced 0 in the abort cycle.
- out_data is held stable while out_valid && !out_ready, because no pop occurs.
- Counters: word_cnt 9 bits, burst_cnt NB_W bits, compared against latched values; no wrap inside a legal job.

## Timing
- Reset (rst_n low, async): state IDLE; buf_clear, out_valid, out_last, busy, done, err = 0; stall_cycles = 0; counters 0. buf_read_en and out_data are combinational and are 0 while in IDLE.
- start at edge t → busy at t+1. If the buffer already holds a burst, first out_valid at t+3 (WAIT, SETTLE, PRESENT).
- Throughput: at most one word per 2 cycles (PRESENT, SETTLE) with out_ready held high.
- Burst boundary: WAIT costs at least one cycle, followed by SETTLE.
- done asserts in the cycle after the final handshake.
- err asserts in the cycle after the illegal start.

## Configuration
- CFU_DRAIN_PERF_EN defined: stall_cycles counts cycles in WAIT plus cycles in PRESENT with out_ready=0. It clears on each accepted start and saturates at 2^32−1.
- Not defined: stall_cycles is tied to 0 and the counter logic is absent. The port remains so the interface is identical.

## Structure
- Shared package cfu_accel_pkg holds the state enum, DEPTH default, the count width (9), and the data width (32).
- Single module with no sub-module. The perf counter is an inline ifdef region.

## Test plan
- Preloaded 8 words 0x10..0x17, burst_len=4, num_bursts=2, out_ready=1 → eight words in order, out_last on 0x13 and 0x17, done one cycle after 0x17, exactly 8 pops.
- Buffer empty, start burst_len=3, words written one every 5 cycles → no out_valid until buf_count=3; first out_data equals first written word.
- out_ready low for 6 cycles mid-burst → out_data stable, no buf_read_en; with PERF_EN, stall_cycles ≥ 6.
- start with burst_len=0, then burst_len=129, then num_bursts=0 → err pulse each time, busy stays 0.
- abort in PRESENT mid-burst → buf_clear one cycle, IDLE next cycle, no done; a following legal start runs normally.
- rst_n low during PRESENT → all outputs 0 immediately, state IDLE after release.
